// File: rtl/decode_queue.sv
// Buffered instruction decoder: a DEPTH-entry FIFO of {pc, instruction} feeding a
// registered decode stage with valid/ready on both sides, branch flush and illegal-opcode tracking.
module decode_queue #(
    parameter int DEPTH    = 4,
    parameter int PC_BITS  = 8,
    parameter int REG_BITS = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [15:0]               in_instruction,
    input  logic [PC_BITS-1:0]        in_pc,
    input  logic                      flush,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [PC_BITS-1:0]        out_pc,
    output logic [REG_BITS-1:0]       decoded_rd_address,
    output logic [REG_BITS-1:0]       decoded_rs_address,
    output logic [REG_BITS-1:0]       decoded_rt_address,
    output logic [2:0]                decoded_nzp,
    output logic [7:0]                decoded_immediate,
    output logic                      decoded_reg_write_enable,
    output logic                      decoded_mem_read_enable,
    output logic                      decoded_mem_write_enable,
    output logic                      decoded_nzp_write_enable,
    output logic [2:0]                decoded_reg_input_mux,
    output logic [1:0]                decoded_alu_arithmetic_mux,
    output logic                      decoded_alu_output_mux,
    output logic                      decoded_pc_mux,
    output logic                      decoded_fma_enable,
    output logic                      decoded_act_enable,
    output logic                      decoded_ret,
    output logic [1:0]                decoded_act_func,
    output logic                      decoded_illegal,
    output logic                      illegal_seen,
    output logic [$clog2(DEPTH):0]    occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_BR    = 4'h1;
    localparam logic [3:0] OP_CMP   = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_SUB   = 4'h4;
    localparam logic [3:0] OP_MUL   = 4'h5;
    localparam logic [3:0] OP_DIV   = 4'h6;
    localparam logic [3:0] OP_LDR   = 4'h7;
    localparam logic [3:0] OP_STR   = 4'h8;
    localparam logic [3:0] OP_CONST = 4'h9;
    localparam logic [3:0] OP_FMA   = 4'hA;
    localparam logic [3:0] OP_ACT   = 4'hB;
    localparam logic [3:0] OP_RET   = 4'hF;

    typedef struct packed {
        logic [REG_BITS-1:0] rd;
        logic [REG_BITS-1:0] rs;
        logic [REG_BITS-1:0] rt;
        logic [2:0]          nzp;
        logic [7:0]          imm;
        logic                reg_write;
        logic                mem_read;
        logic                mem_write;
        logic                nzp_write;
        logic [2:0]          reg_input_mux;
        logic [1:0]          alu_arith;
        logic                alu_output_mux;
        logic                pc_mux;
        logic                fma_enable;
        logic                act_enable;
        logic                ret;
        logic [1:0]          act_func;
        logic                illegal;
    } bundle_t;

    function automatic bundle_t decode(input logic [15:0] instr);
        bundle_t b;
        b          = '0;
        b.rd       = instr[8 +: REG_BITS];
        b.rs       = instr[4 +: REG_BITS];
        b.rt       = instr[0 +: REG_BITS];
        b.nzp      = instr[11:9];
        b.imm      = instr[7:0];
        b.act_func = instr[1:0];
        case (instr[15:12])
            OP_NOP:   ;
            OP_BR:    b.pc_mux = 1'b1;
            OP_CMP:   begin b.alu_output_mux = 1'b1; b.nzp_write = 1'b1; end
            OP_ADD:   begin b.reg_write = 1'b1; b.alu_arith = 2'd0; end
            OP_SUB:   begin b.reg_write = 1'b1; b.alu_arith = 2'd1; end
            OP_MUL:   begin b.reg_write = 1'b1; b.alu_arith = 2'd2; end
            OP_DIV:   begin b.reg_write = 1'b1; b.alu_arith = 2'd3; end
            OP_LDR:   begin b.reg_write = 1'b1; b.mem_read = 1'b1; b.reg_input_mux = 3'd1; end
            OP_STR:   b.mem_write = 1'b1;
            OP_CONST: begin b.reg_write = 1'b1; b.reg_input_mux = 3'd2; end
            OP_FMA:   begin b.reg_write = 1'b1; b.fma_enable = 1'b1; b.reg_input_mux = 3'd3; end
            OP_ACT:   begin b.reg_write = 1'b1; b.act_enable = 1'b1; b.reg_input_mux = 3'd4; end
            OP_RET:   b.ret = 1'b1;
            default:  b.illegal = 1'b1;   // C, D, E are reserved
        endcase
        return b;
    endfunction

    logic [15:0]        instr_mem [DEPTH];
    logic [PC_BITS-1:0] pc_mem    [DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count;
    bundle_t            stage;
    bundle_t            head_bundle;
    logic               push, load;

    // A same-cycle pop deliberately does not open in_ready on a full FIFO.
    assign in_ready    = (count < FULL_COUNT) && !flush;
    assign push        = in_valid && in_ready;
    assign load        = (count != '0) && (!out_valid || out_ready) && !flush;
    assign head_bundle = decode(instr_mem[rd_ptr]);

    // NOTE: storage has no reset; entries are only read when count says they are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr] <= in_instruction;
            pc_mem[wr_ptr]    <= in_pc;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (load) rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(load);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_pc    <= '0;
            stage     <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_pc    <= pc_mem[rd_ptr];
            stage     <= head_bundle;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // A consume during a flush cycle still counts as a completed transfer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            illegal_seen <= 1'b0;
        end else if (out_valid && out_ready && stage.illegal) begin
            illegal_seen <= 1'b1;
        end
    end

    assign occupancy                  = count;
    assign decoded_rd_address         = stage.rd;
    assign decoded_rs_address         = stage.rs;
    assign decoded_rt_address         = stage.rt;
    assign decoded_nzp                = stage.nzp;
    assign decoded_immediate          = stage.imm;
    assign decoded_reg_write_enable   = stage.reg_write;
    assign decoded_mem_read_enable    = stage.mem_read;
    assign decoded_mem_write_enable   = stage.mem_write;
    assign decoded_nzp_write_enable   = stage.nzp_write;
    assign decoded_reg_input_mux      = stage.reg_input_mux;
    assign decoded_alu_arithmetic_mux = stage.alu_arith;
    assign decoded_alu_output_mux     = stage.alu_output_mux;
    assign decoded_pc_mux             = stage.pc_mux;
    assign decoded_fma_enable         = stage.fma_enable;
    assign decoded_act_enable         = stage.act_enable;
    assign decoded_ret                = stage.ret;
    assign decoded_act_func           = stage.act_func;
    assign decoded_illegal            = stage.illegal;

endmodule

// File: tb/tb_decode_queue.sv
// Self-checking bench for decode_queue: opcode table vectors, directed corner sequences,
// and a randomized run against a queue-based reference model.
module tb_decode_queue;

    localparam int DEPTH    = 4;
    localparam int PC_BITS  = 8;
    localparam int REG_BITS = 4;
    localparam int REG_MASK = (1 << REG_BITS) - 1;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   in_valid;
    logic                   in_ready;
    logic [15:0]            in_instruction;
    logic [PC_BITS-1:0]     in_pc;
    logic                   flush;
    logic                   out_valid;
    logic                   out_ready;
    logic [PC_BITS-1:0]     out_pc;
    logic [REG_BITS-1:0]    decoded_rd_address, decoded_rs_address, decoded_rt_address;
    logic [2:0]             decoded_nzp;
    logic [7:0]             decoded_immediate;
    logic                   decoded_reg_write_enable, decoded_mem_read_enable;
    logic                   decoded_mem_write_enable, decoded_nzp_write_enable;
    logic [2:0]             decoded_reg_input_mux;
    logic [1:0]             decoded_alu_arithmetic_mux;
    logic                   decoded_alu_output_mux, decoded_pc_mux, decoded_fma_enable;
    logic                   decoded_act_enable, decoded_ret;
    logic [1:0]             decoded_act_func;
    logic                   decoded_illegal;
    logic                   illegal_seen;
    logic [$clog2(DEPTH):0] occupancy;

    decode_queue #(.DEPTH(DEPTH), .PC_BITS(PC_BITS), .REG_BITS(REG_BITS)) dut (
        .clk                        (clk),
        .reset                      (reset),
        .in_valid                   (in_valid),
        .in_ready                   (in_ready),
        .in_instruction             (in_instruction),
        .in_pc                      (in_pc),
        .flush                      (flush),
        .out_valid                  (out_valid),
        .out_ready                  (out_ready),
        .out_pc                     (out_pc),
        .decoded_rd_address         (decoded_rd_address),
        .decoded_rs_address         (decoded_rs_address),
        .decoded_rt_address         (decoded_rt_address),
        .decoded_nzp                (decoded_nzp),
        .decoded_immediate          (decoded_immediate),
        .decoded_reg_write_enable   (decoded_reg_write_enable),
        .decoded_mem_read_enable    (decoded_mem_read_enable),
        .decoded_mem_write_enable   (decoded_mem_write_enable),
        .decoded_nzp_write_enable   (decoded_nzp_write_enable),
        .decoded_reg_input_mux      (decoded_reg_input_mux),
        .decoded_alu_arithmetic_mux (decoded_alu_arithmetic_mux),
        .decoded_alu_output_mux     (decoded_alu_output_mux),
        .decoded_pc_mux             (decoded_pc_mux),
        .decoded_fma_enable         (decoded_fma_enable),
        .decoded_act_enable         (decoded_act_enable),
        .decoded_ret                (decoded_ret),
        .decoded_act_func           (decoded_act_func),
        .decoded_illegal            (decoded_illegal),
        .illegal_seen               (illegal_seen),
        .occupancy                  (occupancy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [15:0] instr;
        logic [14:0] ctrl;
    } vec_t;

    vec_t        vecs [16];
    logic [14:0] ctrl_by_op [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Control word order: rw, mr, mw, nw, rim[3], aa[2], ao, pcm, fma, act, ret, ill
    function automatic logic [14:0] mk(int rw, int mr, int mw, int nw, int rim, int aa,
                                       int ao, int pcm, int fma, int act, int ret, int ill);
        return {1'(rw), 1'(mr), 1'(mw), 1'(nw), 3'(rim), 2'(aa),
                1'(ao), 1'(pcm), 1'(fma), 1'(act), 1'(ret), 1'(ill)};
    endfunction

    function automatic logic [14:0] ctrl_now();
        return {decoded_reg_write_enable, decoded_mem_read_enable, decoded_mem_write_enable,
                decoded_nzp_write_enable, decoded_reg_input_mux, decoded_alu_arithmetic_mux,
                decoded_alu_output_mux, decoded_pc_mux, decoded_fma_enable,
                decoded_act_enable, decoded_ret, decoded_illegal};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_bundle(input string tag, input logic [15:0] instr, input logic [PC_BITS-1:0] pc);
        check({tag, " out_valid"}, out_valid, 1);
        check({tag, " out_pc"},    out_pc, pc);
        check({tag, " rd"},        decoded_rd_address, 32'(instr[11:8]) & REG_MASK);
        check({tag, " rs"},        decoded_rs_address, 32'(instr[7:4]) & REG_MASK);
        check({tag, " rt"},        decoded_rt_address, 32'(instr[3:0]) & REG_MASK);
        check({tag, " nzp"},       decoded_nzp, instr[11:9]);
        check({tag, " imm"},       decoded_immediate, instr[7:0]);
        check({tag, " act_func"},  decoded_act_func, instr[1:0]);
        check({tag, " ctrl"},      ctrl_now(), ctrl_by_op[instr[15:12]]);
    endtask

    task automatic wait_valid(input string name, input int budget);
        int n = 0;
        while (!out_valid && n < budget) begin
            tick();
            n++;
        end
        check({name, " wait out_valid"}, out_valid, 1);
    endtask

    task automatic idle_inputs();
        in_valid       = 1'b0;
        in_instruction = '0;
        in_pc          = '0;
        flush          = 1'b0;
        out_ready      = 1'b0;
    endtask

    task automatic do_reset();
        #2;
        reset = 1'b1;
        #1;
        check("reset occupancy", occupancy, 0);
        check("reset out_valid", out_valid, 0);
        check("reset in_ready",  in_ready, 1);
        check("reset illegal_seen", illegal_seen, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick();
    endtask

    task automatic push(input logic [15:0] instr, input logic [PC_BITS-1:0] pc);
        in_valid       = 1'b1;
        in_instruction = instr;
        in_pc          = pc;
        tick();
        in_valid       = 1'b0;
    endtask

    // Reference model state for the random phase
    logic [23:0] m_fifo [$];
    logic [23:0] m_stage;
    bit          m_valid;
    bit          m_ill;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic [15:0] stream [3];
        logic [15:0] ri;
        logic [7:0]  rp;
        bit          exp_ready, do_push, load;

        vecs[0]  = '{16'h0000, mk(0,0,0,0,0,0,0,0,0,0,0,0)};
        vecs[1]  = '{16'h1E05, mk(0,0,0,0,0,0,0,1,0,0,0,0)};
        vecs[2]  = '{16'h2012, mk(0,0,0,1,0,0,1,0,0,0,0,0)};
        vecs[3]  = '{16'h3123, mk(1,0,0,0,0,0,0,0,0,0,0,0)};
        vecs[4]  = '{16'h4456, mk(1,0,0,0,0,1,0,0,0,0,0,0)};
        vecs[5]  = '{16'h5789, mk(1,0,0,0,0,2,0,0,0,0,0,0)};
        vecs[6]  = '{16'h6ABC, mk(1,0,0,0,0,3,0,0,0,0,0,0)};
        vecs[7]  = '{16'h7405, mk(1,1,0,0,1,0,0,0,0,0,0,0)};
        vecs[8]  = '{16'h8321, mk(0,0,1,0,0,0,0,0,0,0,0,0)};
        vecs[9]  = '{16'h9A7F, mk(1,0,0,0,2,0,0,0,0,0,0,0)};
        vecs[10] = '{16'hA111, mk(1,0,0,0,3,0,0,0,1,0,0,0)};
        vecs[11] = '{16'hB0C1, mk(1,0,0,0,4,0,0,0,0,1,0,0)};
        vecs[12] = '{16'hC000, mk(0,0,0,0,0,0,0,0,0,0,0,1)};
        vecs[13] = '{16'hD123, mk(0,0,0,0,0,0,0,0,0,0,0,1)};
        vecs[14] = '{16'hE456, mk(0,0,0,0,0,0,0,0,0,0,0,1)};
        vecs[15] = '{16'hF000, mk(0,0,0,0,0,0,0,0,0,0,1,0)};
        for (int i = 0; i < 16; i++) ctrl_by_op[vecs[i].instr[15:12]] = vecs[i].ctrl;

        idle_inputs();
        reset = 1'b1;
        #1;
        check("por in_ready",  in_ready, 1);
        check("por out_valid", out_valid, 0);
        check("por occupancy", occupancy, 0);
        check("por ctrl",      ctrl_now(), 0);
        check("por out_pc",    out_pc, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick();

        // Opcode table
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            push(vecs[i].instr, 8'(i));
            wait_valid("table", 4);
            check_bundle("table", vecs[i].instr, 8'(i));
        end
        tick();

        // Asynchronous reset with a staged bundle and three queued entries
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(16'h3000 | 16'(i), 8'h30 + 8'(i));
        check("midreset pre occupancy", occupancy, 3);
        check("midreset pre out_valid", out_valid, 1);
        do_reset();
        check("midreset post occupancy", occupancy, 0);
        check("midreset post out_valid", out_valid, 0);

        // Latency into an empty queue
        out_ready = 1'b1;
        push(16'h3123, 8'h10);
        check("latency after E out_valid", out_valid, 0);
        check("latency after E occupancy", occupancy, 1);
        tick();
        check_bundle("latency", 16'h3123, 8'h10);
        tick();
        check("latency consumed", out_valid, 0);

        // Fill to DEPTH behind a stalled stage, then drain in order across the wrap
        out_ready = 1'b0;
        for (int k = 0; k <= DEPTH; k++) begin
            check("fill in_ready", in_ready, 1);
            push(16'h4000 | 16'(k), 8'h20 + 8'(k));
        end
        in_valid = 1'b1;
        #1;
        check("full in_ready", in_ready, 0);
        check("full occupancy", occupancy, DEPTH);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k <= DEPTH; k++) begin
            check("drain out_valid", out_valid, 1);
            check("drain out_pc", out_pc, 8'h20 + 8'(k));
            tick();
        end
        check("drain empty out_valid", out_valid, 0);
        check("drain empty occupancy", occupancy, 0);

        // Back-to-back stream at one bundle per cycle
        stream[0] = 16'h7405; stream[1] = 16'h9A7F; stream[2] = 16'hB0C1;
        for (int j = 0; j < 4; j++) begin
            if (j < 3) begin
                in_valid = 1'b1; in_instruction = stream[j]; in_pc = 8'h70 + 8'(j);
            end else begin
                in_valid = 1'b0;
            end
            tick();
            if (j >= 1) check_bundle("stream", stream[j-1], 8'h70 + 8'(j-1));
        end
        check("stream ldr mem_read", 32'(vecs[7].ctrl[13]), 1);
        tick();

        // Flush with a staged bundle and two queued entries, plus a competing in_valid beat
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) push(16'h2000 | 16'(i), 8'h40 + 8'(i));
        check("preflush out_valid", out_valid, 1);
        check("preflush occupancy", occupancy, 2);
        flush = 1'b1; in_valid = 1'b1; in_instruction = 16'h1E05; in_pc = 8'h4F;
        #1;
        check("flush in_ready", in_ready, 0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("postflush out_valid", out_valid, 0);
        check("postflush occupancy", occupancy, 0);
        out_ready = 1'b1;
        push(16'h3456, 8'h55);
        tick();
        check_bundle("postflush first", 16'h3456, 8'h55);
        tick();
        check("postflush single", out_valid, 0);

        // Illegal opcode and the sticky flag
        out_ready = 1'b0;
        push(16'hC000, 8'h60);
        tick();
        check_bundle("illegal", 16'hC000, 8'h60);
        check("illegal_seen before consume", illegal_seen, 0);
        out_ready = 1'b1;
        tick();
        check("illegal_seen after consume", illegal_seen, 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("illegal_seen after flush", illegal_seen, 1);
        push(16'hF000, 8'h61);
        tick();
        check_bundle("ret", 16'hF000, 8'h61);
        check("ret decoded_ret", decoded_ret, 1);
        check("illegal_seen after ret", illegal_seen, 1);
        tick();

        // Randomized traffic against the reference model
        out_ready = 1'b0;
        do_reset();
        m_fifo.delete();
        m_valid = 0;
        m_ill   = 0;
        m_stage = '0;
        for (int c = 0; c < 600; c++) begin
            ri = 16'($urandom);
            rp = 8'($urandom);
            in_valid       = ($urandom_range(0, 2) != 0);
            in_instruction = ri;
            in_pc          = rp;
            out_ready      = (c < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            flush          = ($urandom_range(0, 39) == 0);
            #1;
            exp_ready = (m_fifo.size() < DEPTH) && !flush;
            check("rand in_ready", in_ready, exp_ready);
            check("rand out_valid", out_valid, m_valid);
            check("rand occupancy", occupancy, m_fifo.size());
            check("rand illegal_seen", illegal_seen, m_ill);
            if (m_valid) check_bundle("rand", m_stage[15:0], m_stage[23:16]);

            if (m_valid && out_ready && ctrl_by_op[m_stage[15:12]][0]) m_ill = 1;
            do_push = in_valid && exp_ready;
            if (flush) begin
                m_fifo.delete();
                m_valid = 0;
            end else begin
                load = (m_fifo.size() > 0) && (!m_valid || out_ready);
                if (load) begin
                    m_stage = m_fifo.pop_front();
                    m_valid = 1;
                end else if (out_ready) begin
                    m_valid = 0;
                end
                if (do_push) m_fifo.push_back({rp, ri});
            end
            tick();
        end

        idle_inputs();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_queue.md
Name: decode_queue

Overview:
- Buffered, pipelined successor to the single-slot instruction decoder in the compute core.
- Accepts fetched 16-bit instructions with their PC through a valid/ready handshake and holds them in a parametrised FIFO.
- Decodes the FIFO head into a registered control bundle that the execute stage consumes by its own valid/ready handshake.
- Adds branch flush, illegal-opcode detection and an occupancy report.

Parameters:
- DEPTH, 4: FIFO entries. Must be a power of 2 and at least 2.
- PC_BITS, 8: width of the program-counter tag carried with each instruction.
- REG_BITS, 4: register-address width. Regs are taken from the low REG_BITS of each 4-bit field; must be 1..4.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  queue can accept this cycle.
- in_instruction  in  16  raw instruction word.
- in_pc  in  PC_BITS  PC of in_instruction.
- flush  in  1  taken branch; discards all queued and staged instructions.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  execute consumes the bundle.
- out_pc  out  PC_BITS  PC of the decoded instruction.
- decoded_rd_address, decoded_rs_address, decoded_rt_address  out  REG_BITS each  register fields.
- decoded_nzp  out  3  branch condition.
- decoded_immediate  out  8  immediate field.
- decoded_reg_write_enable, decoded_mem_read_enable, decoded_mem_write_enable, decoded_nzp_write_enable  out  1 each  control signals.
- decoded_reg_input_mux  out  3  register write-back source.
- decoded_alu_arithmetic_mux  out  2  ALU operation select.
- decoded_alu_output_mux, decoded_pc_mux, decoded_fma_enable, decoded_act_enable, decoded_ret  out  1 each  control signals.
- decoded_act_func  out  2  activation function select.
- decoded_illegal  out  1  staged instruction has a reserved opcode.
- illegal_seen  out  1  sticky: an illegal instruction was issued.
- occupancy  out  $clog2(DEPTH)+1  number of FIFO entries, excluding the output stage.

Behaviour:
- Reset values: all outputs 0, except in_ready = 1. FIFO pointers and count are 0.
- Reset is asynchronous and takes effect mid-operation, including mid-handshake; any in-flight instruction is lost.
- Field slicing: opcode = [15:12]; rd = [11:8]; rs = [7:4]; rt = [3:0]; nzp = [11:9]; imm = [7:0]; act_func = [1:0]. Register fields use the low REG_BITS of each 4-bit field.
- Opcode decode:
  - 0 NOP: no enables set.
  - 1 BRnzp: decoded_pc_mux = 1.
  - 2 CMP: decoded_alu_output_mux = 1, decoded_nzp_write_enable = 1.
  - 3 ADD, 4 SUB, 5 MUL, 6 DIV: reg_write = 1, reg_input_mux = 0, alu_arith = 0, 1, 2, 3 respectively.
  - 7 LDR: reg_write = 1, mem_read = 1, reg_input_mux = 1.
  - 8 STR: mem_write = 1.
  - 9 CONST: reg_write = 1, reg_input_mux = 2.
  - A FMA: reg_write = 1, fma_enable = 1, reg_input_mux = 3.
  - B ACT: reg_write = 1, act_enable = 1, reg_input_mux = 4.
  - F RET: decoded_ret = 1.
  - C, D, E: decoded_illegal = 1 with every enable 0.
- Field outputs are always driven from the slice regardless of opcode. All decoded outputs are registered in the output stage.
- Input handshake: transfer occurs when in_valid && in_ready.
  - in_ready = (count < DEPTH) && !flush.
  - A pop in the same cycle does not raise in_ready when the FIFO is full.
- Output stage loads the FIFO head when the FIFO is non-empty and (!out_valid || out_ready). The loaded entry is popped that same cycle.
- Output holding: while out_valid && !out_ready, out_pc and all decoded outputs stay stable.
- Latency: an instruction accepted at edge E into an empty queue with an empty output stage is presented with out_valid = 1 after edge E+1.
- Throughput: 1 instruction per cycle when out_ready is held high.
- FIFO ordering: strict FIFO order. Pointers wrap modulo DEPTH.
- Simultaneous push and pop: count is unchanged. Pushing into an empty FIFO while the output stage loads does not bypass; that instruction loads on the following cycle.
- flush (synchronous, highest priority): at the edge where flush = 1, count = 0, pointers = 0 and out_valid = 0. The in_valid beat in that cycle is discarded because in_ready is 0. A consume in that cycle (out_valid && out_ready) is still a completed transfer.
- illegal_seen: set at the edge where an illegal bundle completes transfer (out_valid && out_ready && decoded_illegal). Cleared only by reset; flush does not clear it.
- occupancy = count and updates every edge.

Test Plan:
- Reset mid-stream with 3 entries queued, then deassert: occupancy = 0, out_valid = 0 and in_ready = 1 immediately on assertion, without waiting for a clock edge.
- Push 0x3123 (ADD r1,r2,r3) at pc 0x10 into the empty queue with out_ready = 1: out_valid after the second edge, with rd = 1, rs = 2, rt = 3, reg_write = 1, alu_arith = 0, out_pc = 0x10.
- Push DEPTH + 1 instructions with out_ready = 0: the first is staged; after DEPTH more accepts, in_ready = 0 and occupancy = DEPTH. Draining with out_ready = 1 returns the PCs in order and wraps the pointers.
- Stream 0x7405, 0x9A7F, 0xB0C1 back-to-back with out_ready = 1:
  - 0x7405 gives mem_read = 1 and reg_input_mux = 1.
  - 0x9A7F gives imm = 0x7F and reg_input_mux = 2.
  - 0xB0C1 gives act_enable = 1 and act_func = 1.
  - One bundle is issued per cycle.
- With 2 entries queued and one staged, pulse flush together with in_valid = 1 on 0x1E05: out_valid = 0, occupancy = 0, the 0x1E05 beat is not accepted, and the next accepted instruction is the first output after flush.
- Issue 0xC000 and consume it: decoded_illegal = 1 with all enables 0. illegal_seen rises after the consume edge and stays 1 across a flush and a subsequent 0xF000 (RET, decoded_ret = 1).
